// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared constants, state encoding and helpers for the
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ISSUE  = 2'd1;
    localparam state_t RDWAIT = 2'd2;

    localparam logic CPU_ID    = 1'b0;
    localparam logic DMA_ID    = 1'b1;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    function automatic logic [1:0] id2onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Requester-side handshake plus data-memory port of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDRSIZE = 12,
    parameter int WIDTH    = 32
);
    logic [1:0]          req;
    logic [1:0]          lock;
    logic [1:0]          we;
    logic [ADDRSIZE-1:0] addr0;
    logic [ADDRSIZE-1:0] addr1;
    logic [WIDTH-1:0]    wdata0;
    logic [WIDTH-1:0]    wdata1;
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [WIDTH-1:0]    rdata;
    logic [ADDRSIZE-1:0] MEM_ADDR;
    logic [WIDTH-1:0]    MEM_OUT;
    logic                MEM_CTRL;
    logic [WIDTH-1:0]    MEM_IN;

    modport slave (
        input  req, lock, we, addr0, addr1, wdata0, wdata1, MEM_IN,
        output gnt, rvalid, rdata, MEM_ADDR, MEM_OUT, MEM_CTRL
    );

    modport master (
        output req, lock, we, addr0, addr1, wdata0, wdata1, MEM_IN,
        input  gnt, rvalid, rdata, MEM_ADDR, MEM_OUT, MEM_CTRL
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_rr_lock_arb.sv
// ============================================================================
// Module      : rr_lock_arb
// Description : Two-way round-robin winner selection with a bounded burst lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_lock_arb #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  wire logic [1:0]       i_req,
    input  wire logic [1:0]       i_lock,
    input  wire logic             i_last,
    input  wire logic [CNT_W-1:0] i_cnt,
    output logic                  o_valid,
    output logic                  o_win,
    output logic [CNT_W-1:0]      o_cnt
);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic w_hold;

    // A zero count means no owner yet, so the lock cannot apply straight after reset.
    assign w_hold = i_req[i_last] & i_lock[i_last] & (i_cnt != '0) & (i_cnt < C_MAX);

    always_comb begin
        o_valid = |i_req;
        o_win   = i_last;
        o_cnt   = C_ONE;
        if (w_hold) begin
            o_win = i_last;
            o_cnt = i_cnt + C_ONE;
        end else if (i_req[~i_last]) begin
            o_win = ~i_last;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one registered data-memory port between CPU and DMA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDRSIZE  = 12,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input wire logic       clk,
    input wire logic       rst,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_valid;
    logic                w_win;
    logic                w_arb_en;
    logic                w_capture;
    logic                w_grant;
    logic [ADDRSIZE-1:0] w_addr;
    logic [WIDTH-1:0]    w_wdata;

    rr_lock_arb #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_arb (
        .i_req   (bus.req),
        .i_lock  (bus.lock),
        .i_last  (r_last),
        .i_cnt   (r_cnt),
        .o_valid (w_valid),
        .o_win   (w_win),
        .o_cnt   (w_cnt_next)
    );

    assign w_addr  = w_win ? bus.addr1  : bus.addr0;
    assign w_wdata = w_win ? bus.wdata1 : bus.wdata0;
    assign w_grant = w_arb_en & w_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_valid ? ISSUE : IDLE;
            ISSUE:   w_next = (bus.MEM_CTRL == MEM_READ) ? RDWAIT
                            : (w_valid ? ISSUE : IDLE);
            RDWAIT:  w_next = w_valid ? ISSUE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A read in ISSUE blocks arbitration for one cycle so its data slot stays free.
    always_comb begin
        w_arb_en  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE:    w_arb_en = 1'b1;
            ISSUE:   w_arb_en = (bus.MEM_CTRL == MEM_WRITE);
            RDWAIT:  begin
                w_arb_en  = 1'b1;
                w_capture = 1'b1;
            end
            default: w_arb_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt      <= 2'b00;
            bus.rvalid   <= 2'b00;
            bus.rdata    <= '0;
            bus.MEM_ADDR <= '0;
            bus.MEM_OUT  <= '0;
            bus.MEM_CTRL <= MEM_READ;
            r_last       <= DMA_ID;
            r_cnt        <= '0;
        end else begin
            bus.gnt    <= w_grant ? id2onehot(w_win) : 2'b00;
            bus.rvalid <= w_capture ? id2onehot(r_last) : 2'b00;
            if (w_capture) begin
                bus.rdata <= bus.MEM_IN;
            end
            if (w_grant) begin
                bus.MEM_ADDR <= w_addr;
                bus.MEM_OUT  <= w_wdata;
                bus.MEM_CTRL <= bus.we[w_win];
                r_last       <= w_win;
                r_cnt        <= w_cnt_next;
            end else begin
                bus.MEM_CTRL <= MEM_READ;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory port (address, write data, read data, read/write control) between the CPU load/store path and a DMA/debug loader. It sits between the requesters and the data memory: it sequences every access, registers all memory-side outputs, and returns read data with a fixed, documented latency. Arbitration is round-robin, with a bounded lock that lets the current owner run a short burst.

## Interface
- ADDRSIZE, 12, data-memory address width
- WIDTH, 32, data word width
- MAX_BURST, 4, maximum consecutive grants to one locked owner (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  2  request; bit 0 = CPU, bit 1 = DMA
- lock  in  2  per-requester burst-hold request; only meaningful with req
- we  in  2  per-requester direction; 1 = write, 0 = read
- addr0, addr1  in  ADDRSIZE  per-requester address
- wdata0, wdata1  in  WIDTH  per-requester write data
- gnt  out  2  one-hot, one-cycle pulse; access issued this cycle
- rvalid  out  2  one-hot, one-cycle pulse; read data valid
- rdata  out  WIDTH  read data, shared by both requesters
- MEM_ADDR  out  ADDRSIZE  memory address, registered
- MEM_OUT  out  WIDTH  memory write data, registered
- MEM_CTRL  out  1  0 = read, 1 = write; registered
- MEM_IN  in  WIDTH  memory read data, valid the cycle after the read address is driven

## Operation
- Reset values: gnt = 0, rvalid = 0, rdata = 0, MEM_ADDR = 0, MEM_OUT = 0, MEM_CTRL = 0, priority pointer → CPU, burst count = 0, state IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt.
  - Dropping req before gnt is legal; no access is issued.
  - Deassert req, or present the next access, in the cycle after gnt.
- FSM has three states:
  - IDLE: if any req, arbitrate and go to ISSUE; otherwise stay.
  - ISSUE: drive the winner's gnt and memory outputs.
    - Write: MEM_CTRL = 1 for this cycle only. Next state is ISSUE if a request is pending, else IDLE.
    - Read: MEM_CTRL = 0. Next state is RDWAIT.
  - RDWAIT: capture MEM_IN into rdata and set rvalid[owner] in the following cycle. Arbitrate in parallel; next state is ISSUE if a request is pending, else IDLE.
- Arbitration (evaluated in IDLE, ISSUE and RDWAIT):
  - Lock: if the last owner has req & lock and burst count < MAX_BURST, the owner wins again and burst count increments.
  - Otherwise, round-robin: the requester other than the last owner wins if requesting; else the last owner. Burst count resets to 1 on any owner change or unlocked grant.
  - Simultaneous req right after reset: CPU wins.
- MEM_CTRL returns to 0 in every cycle without a write. MEM_ADDR and MEM_OUT hold their last values when idle.
- Reset mid-read: the pending rvalid is discarded and not delivered after reset.

## Timing
- Write: req sampled at cycle t → gnt and the MEM_CTRL = 1 write strobe in cycle t+1. Sustained throughput is one write per cycle.
- Read: req at t → gnt and address in t+1 → MEM_IN valid in t+2 → rvalid and rdata in t+3. The next access can issue in t+3.
- rdata holds its value until the next read capture.
- gnt and rvalid for different accesses can coincide (read rvalid in t+3 alongside the next gnt).

## Structure
- Shared package holds:
  - state encoding (IDLE, ISSUE, RDWAIT)
  - requester index constants CPU_ID = 0 and DMA_ID = 1
  - MEM_READ = 0 and MEM_WRITE = 1
- The arbitration function (pointer, lock, burst count → winner) is a natural sub-module, `rr_lock_arb`, reusable for a later instruction-memory arbiter.
- Everything else sits in one always block with asynchronous reset.

## Test plan
- Reset: assert rst mid-read (after the read gnt, before rvalid) → all outputs 0 immediately; no rvalid after release.
- Single CPU write: addr0 = 0x010, wdata0 = 0xDEADBEEF at t → gnt = 01 and MEM_CTRL = 1 in t+1 only, with MEM_ADDR = 0x010 and MEM_OUT = 0xDEADBEEF.
- DMA read: addr1 = 0x020, memory returns 0x12345678 → gnt = 10 at t+1, rvalid = 10 and rdata = 0x12345678 at t+3, MEM_CTRL = 0 throughout.
- Contention: both req held with lock = 0, all writes → gnt alternates 01, 10, 01, 10 in consecutive cycles.
- Burst lock: MAX_BURST = 4; CPU req + lock, DMA req, all writes → four consecutive 01 grants, then 10.
- Dropped request: CPU pulses req for 0 cycles of overlap with arbitration → no gnt and no memory write; MEM_CTRL stays 0.
